// File: rtl/data_mem_pipe.sv
// Data memory for the 16-bit MIPS datapath: one write port, one pipelined
// write-first read port with tag tracking, and a sequential clear engine.
module data_mem_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 3,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_adr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_adr_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              ready_o,
  output logic              init_busy_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int STAGES = READ_LAT - 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rd_rsp_t;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              issue_vld;
  logic              wr_go;
  logic              bypass;
  rd_rsp_t           issue_rsp;

  logic    [STAGES:0] vld_pipe_q;
  rd_rsp_t [STAGES:0] rsp_pipe_q;

  // Status is decoded straight from the state flop so it never glitches.
  assign ready_o     = (state_q == S_RUN);
  assign init_busy_o = (state_q == S_CLEAR);

  assign wr_go     = wr_en_i & ready_o;
  assign issue_vld = rd_en_i & ready_o;
  assign bypass    = wr_en_i & (wr_adr_i == rd_adr_i);

  assign issue_rsp.tag  = rd_tag_i;
  assign issue_rsp.data = bypass ? wr_data_i : mem_q[rd_adr_i];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i)                cnt_d   = '0;
        else if (cnt_q == CNT_MAX) state_d = S_RUN;
      end
      default: begin
        if (clr_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The array itself is never reset; the sweep is what initialises it.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) mem_q[cnt_q]    <= '0;
    else if (wr_go)         mem_q[wr_adr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      rsp_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue_vld;
      rsp_pipe_q[0] <= issue_rsp;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        rsp_pipe_q[s] <= rsp_pipe_q[s-1];
      end
    end
  end

  assign rd_valid_o = vld_pipe_q[STAGES];
  assign rd_data_o  = vld_pipe_q[STAGES] ? rsp_pipe_q[STAGES].data : '0;
  assign rd_tag_o   = vld_pipe_q[STAGES] ? rsp_pipe_q[STAGES].tag  : '0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: three instances (READ_LAT 1..3) share one
// stimulus stream; each is checked against the same hand-computed table.
module tb_data_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, we, re;
  logic [4:0]  wa, ra;
  logic [15:0] wd;
  logic [2:0]  rt;

  logic        rdy [1:3];
  logic        bsy [1:3];
  logic        vld [1:3];
  logic [15:0] dat [1:3];
  logic [2:0]  tg  [1:3];

  data_mem_pipe #(.DATA_W(16), .ADDR_W(5), .TAG_W(3), .READ_LAT(1)) u_l1 (
    .clk_i(clk), .rst(rst), .clr_i(clr), .wr_en_i(we), .wr_adr_i(wa), .wr_data_i(wd),
    .rd_en_i(re), .rd_adr_i(ra), .rd_tag_i(rt), .ready_o(rdy[1]), .init_busy_o(bsy[1]),
    .rd_valid_o(vld[1]), .rd_data_o(dat[1]), .rd_tag_o(tg[1]));
  data_mem_pipe #(.DATA_W(16), .ADDR_W(5), .TAG_W(3), .READ_LAT(2)) u_l2 (
    .clk_i(clk), .rst(rst), .clr_i(clr), .wr_en_i(we), .wr_adr_i(wa), .wr_data_i(wd),
    .rd_en_i(re), .rd_adr_i(ra), .rd_tag_i(rt), .ready_o(rdy[2]), .init_busy_o(bsy[2]),
    .rd_valid_o(vld[2]), .rd_data_o(dat[2]), .rd_tag_o(tg[2]));
  data_mem_pipe #(.DATA_W(16), .ADDR_W(5), .TAG_W(3), .READ_LAT(3)) u_l3 (
    .clk_i(clk), .rst(rst), .clr_i(clr), .wr_en_i(we), .wr_adr_i(wa), .wr_data_i(wd),
    .rd_en_i(re), .rd_adr_i(ra), .rd_tag_i(rt), .ready_o(rdy[3]), .init_busy_o(bsy[3]),
    .rd_valid_o(vld[3]), .rd_data_o(dat[3]), .rd_tag_o(tg[3]));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [2:0]  rt;
    logic        e_vld;
    logic [15:0] e_data;
    logic [2:0]  e_tag;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, int l, logic v, logic [15:0] d, logic [2:0] t);
    chk($sformatf("%s L%0d vld", nm, l), {31'd0, vld[l]}, {31'd0, v});
    chk($sformatf("%s L%0d data", nm, l), {16'd0, dat[l]}, {16'd0, d});
    chk($sformatf("%s L%0d tag", nm, l), {29'd0, tg[l]}, {29'd0, t});
  endtask

  task automatic set_vec(int i, bit w, int a_w, int d_w, bit r, int a_r, int t_r, int e_d);
    tbl[i].we     = w;
    tbl[i].wa     = 5'(a_w);
    tbl[i].wd     = 16'(d_w);
    tbl[i].re     = r;
    tbl[i].ra     = 5'(a_r);
    tbl[i].rt     = 3'(t_r);
    tbl[i].e_vld  = r;
    tbl[i].e_data = r ? 16'(e_d) : 16'h0;
    tbl[i].e_tag  = r ? 3'(t_r) : 3'h0;
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; re = 1'b0;
    wa = '0; wd = '0; ra = '0; rt = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with ready_o low from the current sample; reads cannot be
  // issued during a sweep, so every output must stay idle meanwhile.
  task automatic count_low(string nm, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (rdy[1] !== 1'b0) break;
      n++;
      chk($sformatf("%s L3 vld idle", nm), {31'd0, vld[3]}, 32'd0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int src;
    // write, read-after-write, bypass, in-flight hazard, back-to-back, zeros
    set_vec( 0, 1,  5, 'hBEEF, 0,  0, 0, 0);
    set_vec( 1, 0,  0, 0,      1,  5, 3, 'hBEEF);
    set_vec( 2, 0,  0, 0,      0,  0, 0, 0);
    set_vec( 3, 1,  9, 'h1234, 1,  9, 5, 'h1234);
    set_vec( 4, 0,  0, 0,      1,  9, 6, 'h1234);
    set_vec( 5, 1,  9, 'h5555, 0,  0, 0, 0);
    set_vec( 6, 0,  0, 0,      1,  9, 7, 'h5555);
    set_vec( 7, 1,  1, 'h0011, 0,  0, 0, 0);
    set_vec( 8, 1,  2, 'h0022, 0,  0, 0, 0);
    set_vec( 9, 1,  3, 'h0033, 1,  1, 1, 'h0011);
    set_vec(10, 0,  0, 0,      1,  2, 2, 'h0022);
    set_vec(11, 0,  0, 0,      1,  3, 3, 'h0033);
    set_vec(12, 0,  0, 0,      1,  0, 0, 'h0000);
    set_vec(13, 0,  0, 0,      1, 17, 4, 'h0000);
    set_vec(14, 0,  0, 0,      1, 31, 7, 'h0000);
    set_vec(15, 1, 31, 'hFFFF, 1, 30, 2, 'h0000);
    set_vec(16, 0,  0, 0,      1, 31, 1, 'hFFFF);
    set_vec(17, 1,  4, 'h00AA, 0,  0, 0, 0);
    set_vec(18, 0,  0, 0,      0,  0, 0, 0);
    set_vec(19, 0,  0, 0,      0,  0, 0, 0);
    set_vec(20, 0,  0, 0,      0,  0, 0, 0);

    // reset state and the initial sweep
    idle();
    rst = 1'b0;
    #1;
    for (int l = 1; l <= 3; l++) begin
      chk_out("reset", l, 1'b0, 16'h0, 3'h0);
      chk($sformatf("reset L%0d ready", l), {31'd0, rdy[l]}, 32'd0);
      chk($sformatf("reset L%0d busy", l), {31'd0, bsy[l]}, 32'd1);
    end
    repeat (3) step();
    rst = 1'b1;
    count_low("init sweep", n);
    chk("init sweep length", n, 32);
    chk("init busy after sweep", {31'd0, bsy[1]}, 32'd0);

    // table: result of vector j appears READ_LAT samples after it is driven
    for (int j = 0; j < NV; j++) begin
      step();
      for (int l = 1; l <= 3; l++) begin
        src = j - l;
        if (src >= 0) chk_out($sformatf("vec%0d", src), l, tbl[src].e_vld, tbl[src].e_data, tbl[src].e_tag);
        else          chk_out("pre", l, 1'b0, 16'h0, 3'h0);
      end
      chk($sformatf("vec%0d ready", j), {31'd0, rdy[3]}, 32'd1);
      we = tbl[j].we; wa = tbl[j].wa; wd = tbl[j].wd;
      re = tbl[j].re; ra = tbl[j].ra; rt = tbl[j].rt;
    end

    // clr while a read of address 4 is in flight
    step();
    idle();
    re = 1'b1; ra = 5'd4; rt = 3'd4;
    step();
    chk_out("clr inflight", 1, 1'b1, 16'h00AA, 3'd4);
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    we = 1'b1; wa = 5'd4; wd = 16'h1111;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (rdy[1] !== 1'b0) break;
      n++;
      if (k == 0) chk_out("clr inflight", 2, 1'b1, 16'h00AA, 3'd4);
      if (k == 1) chk_out("clr inflight", 3, 1'b1, 16'h00AA, 3'd4);
      step();
    end
    chk("clr sweep length", n, 32);
    idle();
    re = 1'b1; ra = 5'd4; rt = 3'd2;
    step();
    idle();
    chk_out("after clr addr4", 1, 1'b1, 16'h0000, 3'd2);

    // reset one cycle after a read issue
    we = 1'b1; wa = 5'd7; wd = 16'h7777;
    step();
    idle();
    re = 1'b1; ra = 5'd7; rt = 3'd5;
    step();
    idle();
    chk_out("pre-rst", 1, 1'b1, 16'h7777, 3'd5);
    #2;
    rst = 1'b0;
    #1;
    for (int l = 1; l <= 3; l++) begin
      chk_out("async rst", l, 1'b0, 16'h0, 3'h0);
      chk($sformatf("async rst L%0d ready", l), {31'd0, rdy[l]}, 32'd0);
      chk($sformatf("async rst L%0d busy", l), {31'd0, bsy[l]}, 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("rst hold", 2, 1'b0, 16'h0, 3'h0);
      chk_out("rst hold", 3, 1'b0, 16'h0, 3'h0);
    end
    rst = 1'b1;
    count_low("rst sweep", n);
    chk("rst sweep length", n, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
Parametrised data memory for the 16-bit MIPS datapath, the successor to the single-port combinational-read data memory. It has one write port and one pipelined read port. The read latency is configurable, reads use write-first bypass, and each read carries a destination-register tag through the pipe for writeback. A sequential clear engine zeroes the array after reset or on request, and holds off requests until it finishes.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W words
TAG_W, 3, width of the destination-register tag carried with each read
READ_LAT, 1, read latency in cycles from issue to rd_valid_o; legal values 1..3

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
clr_i  in  1  single-cycle pulse; restarts the clear sweep
wr_en_i  in  1  write request
wr_adr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  write data
rd_en_i  in  1  read request
rd_adr_i  in  ADDR_W  read address
rd_tag_i  in  TAG_W  destination register for the read data
ready_o  out  1  1 = requests are accepted this cycle
init_busy_o  out  1  1 = clear sweep in progress
rd_valid_o  out  1  read result valid
rd_data_o  out  DATA_W  read data
rd_tag_o  out  TAG_W  tag returned with the read data

Behaviour:
- FSM states: CLEAR, RUN.
- On rst low: state = CLEAR, sweep counter = 0, all pipeline valid bits = 0.
- Reset values of outputs: rd_valid_o = 0, rd_data_o = 0, rd_tag_o = 0, ready_o = 0, init_busy_o = 1.
- CLEAR: writes 0 to ram[counter] each cycle and increments the counter. After writing the last address (2**ADDR_W - 1), the counter wraps to 0 and the FSM moves to RUN on the next edge. The sweep therefore takes exactly 2**ADDR_W cycles. ready_o = 0 and init_busy_o = 1 throughout.
- RUN: ready_o = 1, init_busy_o = 0.
- clr_i in RUN: next state = CLEAR, counter = 0. clr_i in CLEAR: counter restarts from 0.
- Outputs ready_o and init_busy_o are decoded from the state register (registered, glitch-free).
- Request gating: wr_en_i and rd_en_i are honoured only in a cycle where ready_o = 1. Otherwise they are ignored: no write, no pipeline entry.
- Write: ram[wr_adr_i] <= wr_data_i at the edge.
- Read issue (RUN, rd_en_i = 1): the array is sampled at the issue edge.
  - If wr_en_i = 1 and wr_adr_i == rd_adr_i in the same cycle, the captured data is wr_data_i (write-first bypass).
  - The captured data and rd_tag_i enter pipeline stage 1 with valid = 1.
- Pipeline: READ_LAT register stages, each holding valid, data and tag.
  - A read issued at edge N appears at rd_valid_o / rd_data_o / rd_tag_o after edge N + READ_LAT - 1 and is visible for exactly one cycle. With READ_LAT = 1 the result is visible in the cycle immediately after issue.
  - Data is fixed at issue; writes in later cycles do not alter in-flight reads.
  - No back-pressure: one read per cycle sustained, results in issue order.
- When the output stage valid = 0, rd_data_o and rd_tag_o are driven to 0 (no stale data).
- Pipeline valid bits advance independently of FSM state. Reads in flight when clr_i is asserted still complete with their captured pre-clear data.
- Reset mid-operation: asynchronous clear of the FSM, counter and all valid/data/tag stages. In-flight reads are discarded. Array contents are undefined until the sweep completes.
- Addresses are exactly ADDR_W bits, with no out-of-range case. Data is passed unmodified: no sign extension, no byte lanes.

Test Plan:
- Reset release, ADDR_W = 5 → ready_o = 0 for 32 cycles, then 1. After the sweep, reads of addresses 0, 17 and 31 return 16'h0000.
- RUN: write 16'hBEEF to address 5, then read 5 with tag 3, READ_LAT = 2 → rd_valid_o high exactly 2 cycles after issue, rd_data_o = 16'hBEEF, rd_tag_o = 3, and high for one cycle only.
- Same-cycle write 16'h1234 and read of address 9, READ_LAT = 1 → rd_data_o = 16'h1234 on the next cycle (bypass). Then a write of 16'h5555 to address 9 one cycle after issuing a second read of address 9, READ_LAT = 3 → the second read still returns 16'h1234.
- Back-to-back reads of addresses 1, 2, 3 (pre-written 16'h0011, 16'h0022, 16'h0033), tags 1, 2, 3 → three consecutive valid cycles, in order, with matching data and tags.
- clr_i pulse while a read of address 4 (value 16'h00AA) is in flight, READ_LAT = 3 → that read returns 16'h00AA. ready_o = 0 for 32 cycles; wr_en_i during the sweep has no effect; address 4 reads back 16'h0000 afterwards.
- rst asserted low one cycle after a read issue, READ_LAT = 2 → rd_valid_o never rises, all outputs 0 immediately (asynchronously), and the sweep restarts on release.
